// File: rtl/idu_regfile_ysyx_23060136_pkg.sv
// Shared constants for the IDU register files: data width, mstatus reset value
// and the 3-bit CSR index encoding used on the write-back and read ports.
package DEFINES_ysyx_23060136;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned CSR_NUM     = 7;
   localparam logic [31:0] MSTATUS_RST = 32'h0000_1800;

   typedef enum logic [2:0] {
      CSR_MSTATUS  = 3'd0,
      CSR_MTVEC    = 3'd1,
      CSR_MEPC     = 3'd2,
      CSR_MCAUSE   = 3'd3,
      CSR_MSCRATCH = 3'd4,
      CSR_MCYCLE   = 3'd5,
      CSR_MINSTRET = 3'd6,
      CSR_RSVD     = 3'd7
   } csr_idx_e;

endpackage

// File: rtl/idu_regfile_ysyx_23060136_csr.sv
// Machine CSR file: write-back CSR writes, trap capture with priority over
// same-cycle mepc/mcause writes, free-running counters and the sticky halt flag.
module csr_file_ysyx_23060136
   import DEFINES_ysyx_23060136::*;
#(
   parameter int unsigned XLEN        = DEFINES_ysyx_23060136::XLEN,
   parameter logic [XLEN-1:0] MSTATUS_RST = DEFINES_ysyx_23060136::MSTATUS_RST
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] csr_busW,
   input  logic [2:0]      csr_rd,
   input  logic            csr_wr,
   input  logic            commit,
   input  logic            system_halt,
   input  logic            exc_valid,
   input  logic [XLEN-1:0] exc_pc,
   input  logic [XLEN-1:0] exc_cause,
   input  logic [2:0]      csr_rs,
   output logic [XLEN-1:0] csr_rs_data,
   output logic [XLEN-1:0] mtvec,
   output logic [XLEN-1:0] mepc,
   output logic            halted
);

   logic [XLEN-1:0] csr_q [CSR_NUM];
   logic [XLEN-1:0] csr_d [CSR_NUM];
   logic            halted_q, halted_d;

   // Later assignments override earlier ones: counter increment, then CSR write,
   // then trap capture, which gives the required priority order.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      csr_d    = csr_q;
      halted_d = halted_q;
      if (!halted_q) begin
         csr_d[CSR_MCYCLE] = csr_q[CSR_MCYCLE] + 1'b1;
         if (commit)
            csr_d[CSR_MINSTRET] = csr_q[CSR_MINSTRET] + 1'b1;
         if (csr_wr && csr_rd != CSR_RSVD)
            csr_d[csr_rd] = csr_busW;
         if (exc_valid) begin
            csr_d[CSR_MEPC]   = exc_pc;
            csr_d[CSR_MCAUSE] = exc_cause;
         end
      end
      if (commit && system_halt)
         halted_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CSR_NUM; i++)
            csr_q[i] <= '0;
         csr_q[CSR_MSTATUS] <= MSTATUS_RST;
         halted_q           <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         csr_q    <= csr_d;
         halted_q <= halted_d;
      end
   end

   assign csr_rs_data = (csr_rs == CSR_RSVD) ? '0 : csr_q[csr_rs];
   assign mtvec       = csr_q[CSR_MTVEC];
   assign mepc        = csr_q[CSR_MEPC];
   assign halted      = halted_q;

endmodule

// File: rtl/idu_regfile_ysyx_23060136.sv
// IDU-side GPR file and CSR read path fed by the WB write bus.
// Define RF_BYPASS_EN to make same-cycle writes visible on the read ports.
module idu_regfile_ysyx_23060136
   import DEFINES_ysyx_23060136::*;
#(
   parameter int unsigned XLEN        = DEFINES_ysyx_23060136::XLEN,
   parameter int unsigned GPR_NUM     = 32,
   parameter logic [XLEN-1:0] MSTATUS_RST = DEFINES_ysyx_23060136::MSTATUS_RST
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] IDU_i_rf_busW,
   input  logic [4:0]      IDU_i_rd,
   input  logic            IDU_i_RegWr,
   input  logic [XLEN-1:0] IDU_i_csr_busW,
   input  logic [2:0]      IDU_i_csr_rd,
   input  logic            IDU_i_CSRWr,
   input  logic            IDU_i_commit,
   input  logic            IDU_i_system_halt,
   input  logic            IDU_i_exc_valid,
   input  logic [XLEN-1:0] IDU_i_exc_pc,
   input  logic [XLEN-1:0] IDU_i_exc_cause,
   input  logic [4:0]      IDU_i_rs1,
   input  logic [4:0]      IDU_i_rs2,
   input  logic [2:0]      IDU_i_csr_rs,
   output logic [XLEN-1:0] IDU_o_rs1_data,
   output logic [XLEN-1:0] IDU_o_rs2_data,
   output logic [XLEN-1:0] IDU_o_csr_rs_data,
   output logic [XLEN-1:0] IDU_o_mtvec,
   output logic [XLEN-1:0] IDU_o_mepc,
   output logic            IDU_o_halted
);

   logic [XLEN-1:0] gpr_q [GPR_NUM];
   logic [XLEN-1:0] gpr_d [GPR_NUM];
   logic [XLEN-1:0] csr_stored;
   logic            halted;
   logic            gpr_wr;

   assign gpr_wr = IDU_i_RegWr && (IDU_i_rd != 5'd0) && !halted;

   always_comb begin
      gpr_d = gpr_q;
      if (gpr_wr)
         gpr_d[IDU_i_rd] = IDU_i_rf_busW;
      gpr_d[0] = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the GPR array is reset explicitly because architectural state must read 0 after reset.
         for (int i = 0; i < GPR_NUM; i++)
            gpr_q[i] <= '0;
      end else begin
         gpr_q <= gpr_d;
      end
   end

   csr_file_ysyx_23060136 #(
      .XLEN        (XLEN),
      .MSTATUS_RST (MSTATUS_RST)
   ) u_csr (
      .clk         (clk),
      .rst_n       (rst_n),
      .csr_busW    (IDU_i_csr_busW),
      .csr_rd      (IDU_i_csr_rd),
      .csr_wr      (IDU_i_CSRWr),
      .commit      (IDU_i_commit),
      .system_halt (IDU_i_system_halt),
      .exc_valid   (IDU_i_exc_valid),
      .exc_pc      (IDU_i_exc_pc),
      .exc_cause   (IDU_i_exc_cause),
      .csr_rs      (IDU_i_csr_rs),
      .csr_rs_data (csr_stored),
      .mtvec       (IDU_o_mtvec),
      .mepc        (IDU_o_mepc),
      .halted      (halted)
   );

   always_comb begin
      IDU_o_rs1_data    = (IDU_i_rs1 == 5'd0) ? '0 : gpr_q[IDU_i_rs1];
      IDU_o_rs2_data    = (IDU_i_rs2 == 5'd0) ? '0 : gpr_q[IDU_i_rs2];
      IDU_o_csr_rs_data = csr_stored;
`ifdef RF_BYPASS_EN
      // gpr_wr already excludes x0, so a same-cycle x0 read still returns 0.
      if (gpr_wr && IDU_i_rs1 == IDU_i_rd)
         IDU_o_rs1_data = IDU_i_rf_busW;
      if (gpr_wr && IDU_i_rs2 == IDU_i_rd)
         IDU_o_rs2_data = IDU_i_rf_busW;
      if (IDU_i_CSRWr && !halted && IDU_i_csr_rs == IDU_i_csr_rd && IDU_i_csr_rd != CSR_RSVD)
         IDU_o_csr_rs_data = IDU_i_csr_busW;
`endif
   end

   assign IDU_o_halted = halted;

endmodule

// File: tb/tb_idu_regfile_ysyx_23060136.sv
// Self-checking bench for idu_regfile_ysyx_23060136: table of single-edge
// vectors checked through a scoreboard queue, plus bypass/halt/reset sequences.
module tb_idu_regfile_ysyx_23060136;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] rf_busW, csr_busW, exc_pc, exc_cause;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  csr_rd, csr_rs;
   logic        regwr, csrwr, commit, sys_halt, exc_valid;
   logic [31:0] rs1_data, rs2_data, csr_data, mtvec, mepc;
   logic        halted;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        regwr;  logic [4:0] rd;     logic [31:0] busw;
      logic        csrwr;  logic [2:0] csr_rd; logic [31:0] csr_busw;
      logic        commit; logic       exc;    logic [31:0] exc_pc; logic [31:0] exc_cause;
      logic [4:0]  rs1;    logic [4:0] rs2;    logic [2:0]  csr_rs;
      logic [31:0] e_rs1;  logic [31:0] e_rs2; logic [31:0] e_csr;
      logic [31:0] e_mtvec; logic [31:0] e_mepc;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];

   always #5 clk = ~clk;

   idu_regfile_ysyx_23060136 dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .IDU_i_rf_busW     (rf_busW),
      .IDU_i_rd          (rd),
      .IDU_i_RegWr       (regwr),
      .IDU_i_csr_busW    (csr_busW),
      .IDU_i_csr_rd      (csr_rd),
      .IDU_i_CSRWr       (csrwr),
      .IDU_i_commit      (commit),
      .IDU_i_system_halt (sys_halt),
      .IDU_i_exc_valid   (exc_valid),
      .IDU_i_exc_pc      (exc_pc),
      .IDU_i_exc_cause   (exc_cause),
      .IDU_i_rs1         (rs1),
      .IDU_i_rs2         (rs2),
      .IDU_i_csr_rs      (csr_rs),
      .IDU_o_rs1_data    (rs1_data),
      .IDU_o_rs2_data    (rs2_data),
      .IDU_o_csr_rs_data (csr_data),
      .IDU_o_mtvec       (mtvec),
      .IDU_o_mepc        (mepc),
      .IDU_o_halted      (halted)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic idle();
      regwr = 0; csrwr = 0; commit = 0; sys_halt = 0; exc_valid = 0;
      rd = '0; rf_busW = '0; csr_rd = '0; csr_busW = '0; exc_pc = '0; exc_cause = '0;
   endtask

   function automatic vec_t mk(
      input logic rw, input logic [4:0] d, input logic [31:0] bw,
      input logic cw, input logic [2:0] cd, input logic [31:0] cbw,
      input logic cm, input logic ex, input logic [31:0] epc, input logic [31:0] ecause,
      input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] cr,
      input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] ec,
      input logic [31:0] etv, input logic [31:0] eep);
      vec_t v;
      v.regwr = rw; v.rd = d; v.busw = bw; v.csrwr = cw; v.csr_rd = cd; v.csr_busw = cbw;
      v.commit = cm; v.exc = ex; v.exc_pc = epc; v.exc_cause = ecause;
      v.rs1 = r1; v.rs2 = r2; v.csr_rs = cr;
      v.e_rs1 = e1; v.e_rs2 = e2; v.e_csr = ec; v.e_mtvec = etv; v.e_mepc = eep;
      return v;
   endfunction

   // Drive one vector before an edge, then read with write enables idle.
   task automatic apply(input vec_t v);
      vec_t e;
      @(negedge clk);
      regwr = v.regwr; rd = v.rd; rf_busW = v.busw;
      csrwr = v.csrwr; csr_rd = v.csr_rd; csr_busW = v.csr_busw;
      commit = v.commit; exc_valid = v.exc; exc_pc = v.exc_pc; exc_cause = v.exc_cause;
      sb.push_back(v);
      @(posedge clk);
      #1 idle();
      rs1 = v.rs1; rs2 = v.rs2; csr_rs = v.csr_rs;
      #1;
      e = sb.pop_front();
      check("rs1_data", rs1_data, e.e_rs1);
      check("rs2_data", rs2_data, e.e_rs2);
      check("csr_rs_data", csr_data, e.e_csr);
      check("mtvec", mtvec, e.e_mtvec);
      check("mepc", mepc, e.e_mepc);
      check("halted", {31'd0, halted}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //          rw d   busw          cw cd  cbw           cm ex epc           cause      r1  r2 cr  e_rs1         e_rs2         e_csr         e_mtvec       e_mepc
      vecs.push_back(mk(1, 5, 32'hDEAD_BEEF, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0,   5,  0, 0, 32'hDEAD_BEEF, 32'h0,        32'h1800,      32'h0,         32'h0));
      vecs.push_back(mk(1, 0, 32'h0000_1234, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0,   0,  5, 7, 32'h0,         32'hDEAD_BEEF, 32'h0,        32'h0,         32'h0));
      vecs.push_back(mk(0, 0, 32'h0,         1, 2, 32'h0000_AAAA, 0, 1, 32'h8000_0010, 32'hB,   5,  0, 2, 32'hDEAD_BEEF, 32'h0,        32'h8000_0010, 32'h0,         32'h8000_0010));
      vecs.push_back(mk(0, 0, 32'h0,         1, 4, 32'h0000_AAAA, 0, 1, 32'h8000_0020, 32'h2,   5,  0, 4, 32'hDEAD_BEEF, 32'h0,        32'h0000_AAAA, 32'h0,         32'h8000_0020));
      vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 32'h0,         32'h0,   5,  0, 3, 32'hDEAD_BEEF, 32'h0,        32'h2,         32'h0,         32'h8000_0020));
      vecs.push_back(mk(0, 0, 32'h0,         1, 1, 32'h8000_0100, 0, 0, 32'h0,         32'h0,   5,  0, 1, 32'hDEAD_BEEF, 32'h0,        32'h8000_0100, 32'h8000_0100, 32'h8000_0020));
      vecs.push_back(mk(0, 0, 32'h0,         1, 7, 32'hFFFF_FFFF, 0, 0, 32'h0,         32'h0,   5,  0, 7, 32'hDEAD_BEEF, 32'h0,        32'h0,         32'h8000_0100, 32'h8000_0020));
      vecs.push_back(mk(0, 0, 32'h0,         1, 0, 32'h0000_0088, 0, 0, 32'h0,         32'h0,   5,  0, 0, 32'hDEAD_BEEF, 32'h0,        32'h88,        32'h8000_0100, 32'h8000_0020));
      vecs.push_back(mk(0, 0, 32'h0,         1, 6, 32'h0,         1, 0, 32'h0,         32'h0,   5,  0, 6, 32'hDEAD_BEEF, 32'h0,        32'h0,         32'h8000_0100, 32'h8000_0020));
      vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h0,         32'h0,   5,  0, 6, 32'hDEAD_BEEF, 32'h0,        32'h1,         32'h8000_0100, 32'h8000_0020));
      vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h0,         32'h0,   5,  0, 6, 32'hDEAD_BEEF, 32'h0,        32'h2,         32'h8000_0100, 32'h8000_0020));
      vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h0,         32'h0,   5,  0, 6, 32'hDEAD_BEEF, 32'h0,        32'h3,         32'h8000_0100, 32'h8000_0020));
      vecs.push_back(mk(0, 0, 32'h0,         1, 6, 32'hFFFF_FFFF, 0, 0, 32'h0,         32'h0,   5,  0, 6, 32'hDEAD_BEEF, 32'h0,        32'hFFFF_FFFF, 32'h8000_0100, 32'h8000_0020));
      vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h0,         32'h0,   5,  0, 6, 32'hDEAD_BEEF, 32'h0,        32'h0,         32'h8000_0100, 32'h8000_0020));
      vecs.push_back(mk(0, 0, 32'h0,         1, 6, 32'h5,         1, 0, 32'h0,         32'h0,   5,  0, 6, 32'hDEAD_BEEF, 32'h0,        32'h5,         32'h8000_0100, 32'h8000_0020));
      vecs.push_back(mk(0, 0, 32'h0,         1, 5, 32'd100,       0, 0, 32'h0,         32'h0,   5,  0, 5, 32'hDEAD_BEEF, 32'h0,        32'd100,       32'h8000_0100, 32'h8000_0020));
      vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 32'h0,         32'h0,   5,  0, 5, 32'hDEAD_BEEF, 32'h0,        32'd101,       32'h8000_0100, 32'h8000_0020));
      vecs.push_back(mk(1, 31, 32'h0F0F_0F0F, 0, 0, 32'h0,        0, 0, 32'h0,         32'h0,   31, 5, 2, 32'h0F0F_0F0F, 32'hDEAD_BEEF, 32'h8000_0020, 32'h8000_0100, 32'h8000_0020));
      vecs.push_back(mk(0, 0, 32'h0,         1, 3, 32'h0000_AAAA, 0, 1, 32'h8000_0030, 32'h7,   31, 5, 3, 32'h0F0F_0F0F, 32'hDEAD_BEEF, 32'h7,         32'h8000_0100, 32'h8000_0030));
      vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 32'h0,         32'h0,   31, 5, 4, 32'h0F0F_0F0F, 32'hDEAD_BEEF, 32'h0000_AAAA, 32'h8000_0100, 32'h8000_0030));

      rst_n = 1'b0;
      idle();
      rs1 = 5; rs2 = 0; csr_rs = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("reset rs1_data", rs1_data, 32'h0);
      check("reset mstatus", csr_data, 32'h0000_1800);
      check("reset mepc", mepc, 32'h0);
      check("reset mtvec", mtvec, 32'h0);
      check("reset halted", {31'd0, halted}, 32'd0);

      // mcycle counts ten edges after reset release.
      repeat (10) @(posedge clk);
      #1 csr_rs = 5;
      #1 check("mcycle after 10", csr_data, 32'd10);

      foreach (vecs[i]) apply(vecs[i]);
      check("scoreboard drained", 32'(sb.size()), 32'd0);

      // Same-cycle read of a register being written.
      @(negedge clk);
      regwr = 1; rd = 3; rf_busW = 32'h55; rs2 = 3; rs1 = 0;
      #1;
`ifdef RF_BYPASS_EN
      check("rs2 same cycle", rs2_data, 32'h55);
`else
      check("rs2 same cycle", rs2_data, 32'h0);
`endif
      @(posedge clk);
      #1 idle();
      #1 check("rs2 next cycle", rs2_data, 32'h55);
      @(negedge clk);
      regwr = 1; rd = 0; rf_busW = 32'h1234; rs1 = 0;
      #1 check("x0 same cycle", rs1_data, 32'h0);
      @(posedge clk);
      #1 idle();

      // system_halt without commit is ignored.
      @(negedge clk);
      sys_halt = 1;
      @(posedge clk);
      #1 idle();
      #1 check("halt w/o commit", {31'd0, halted}, 32'd0);

      // Halting commit still performs its own writes.
      @(negedge clk);
      commit = 1; sys_halt = 1; regwr = 1; rd = 1; rf_busW = 32'd7;
      csrwr = 1; csr_rd = 5; csr_busW = 32'd500;
      @(posedge clk);
      #1 idle();
      rs1 = 1; csr_rs = 5;
      #1;
      check("halt x1", rs1_data, 32'd7);
      check("halt mcycle", csr_data, 32'd500);
      check("halt flag", {31'd0, halted}, 32'd1);
      csr_rs = 6;
      #1 check("halt minstret", csr_data, 32'd6);

      // Everything is frozen once halted.
      @(negedge clk);
      regwr = 1; rd = 1; rf_busW = 32'd9; csrwr = 1; csr_rd = 4; csr_busW = 32'h1234;
      commit = 1; exc_valid = 1; exc_pc = 32'h1; exc_cause = 32'h1;
      repeat (3) @(posedge clk);
      #1 idle();
      rs1 = 1; csr_rs = 5;
      #1;
      check("frozen x1", rs1_data, 32'd7);
      check("frozen mcycle", csr_data, 32'd500);
      check("frozen mepc", mepc, 32'h8000_0030);
      check("frozen halted", {31'd0, halted}, 32'd1);
      csr_rs = 4;
      #1 check("frozen mscratch", csr_data, 32'h0000_AAAA);
      csr_rs = 6;
      #1 check("frozen minstret", csr_data, 32'd6);

      // Asynchronous reset away from any clock edge.
      @(posedge clk);
      #3 rst_n = 1'b0;
      csr_rs = 0; rs1 = 1;
      #1;
      check("async rst x1", rs1_data, 32'h0);
      check("async rst mstatus", csr_data, 32'h0000_1800);
      check("async rst halted", {31'd0, halted}, 32'd0);
      check("async rst mepc", mepc, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
